// File: rtl/mouse_pkg.sv
// Shared board geometry, coordinate widths and FSM state encoding
// for the mouse-driven tile move controller.
package mouse_pkg;

    localparam int X_BLOCKS = 18;
    localparam int Y_BLOCKS = 8;
    localparam int BX_W     = 5;
    localparam int BY_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SRC  = 2'd1,
        S_REQ  = 2'd2
    } state_t;

endpackage

// File: rtl/timeout_counter.sv
// Saturating up-counter for the move-acknowledge timeout; done is high
// while the count sits at TIMEOUT-1.
module timeout_counter #(
    parameter int unsigned TIMEOUT = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (en && (cnt != TC)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == TC);

endmodule

// File: rtl/mouse_move_ctrl.sv
// Two-click tile move sequencer: select source, select destination, then
// hold a move request toward game logic until acknowledged or timed out.
//
//   state  | meaning
//   S_IDLE | nothing selected, waiting for a source click
//   S_SRC  | source tile selected, waiting for a destination click
//   S_REQ  | move_req held, waiting for move_ack / timeout / cancel
module mouse_move_ctrl
    import mouse_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 24'd10_000_000,
    parameter int unsigned X_BLOCKS    = mouse_pkg::X_BLOCKS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            interboard_rst,
    input  logic            en,
    input  logic            l_click,
    input  logic            r_click,
    input  logic            mouse_inblock,
    input  logic [BX_W-1:0] mouse_block_x,
    input  logic [BY_W-1:0] mouse_block_y,
    input  logic            move_ack,
    output logic            sel_valid,
    output logic [BX_W-1:0] sel_x,
    output logic [BY_W-1:0] sel_y,
    output logic            move_req,
    output logic [BX_W-1:0] move_src_x,
    output logic [BY_W-1:0] move_src_y,
    output logic [BX_W-1:0] move_dst_x,
    output logic [BY_W-1:0] move_dst_y,
    output logic            move_fail,
    output logic            busy
);

    state_t          state, state_nxt;
    logic            sel_valid_nxt;
    logic [BX_W-1:0] sel_x_nxt;
    logic [BY_W-1:0] sel_y_nxt;
    logic            move_req_nxt;
    logic [BX_W-1:0] move_src_x_nxt;
    logic [BY_W-1:0] move_src_y_nxt;
    logic [BX_W-1:0] move_dst_x_nxt;
    logic [BY_W-1:0] move_dst_y_nxt;
    logic            move_fail_nxt;

    logic            valid_click;
    logic            same_block;
    logic            tmo_done;

    assign valid_click = l_click && en && mouse_inblock
                         && (32'(mouse_block_x) < X_BLOCKS)
                         && (32'(mouse_block_y) < Y_BLOCKS);
    assign same_block  = (mouse_block_x == sel_x) && (mouse_block_y == sel_y);

    // Counter is held cleared outside S_REQ so every request starts from zero.
    timeout_counter #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state != S_REQ) || interboard_rst),
        .en    (state == S_REQ),
        .done  (tmo_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || interboard_rst) begin
            state      <= S_IDLE;
            sel_valid  <= 1'b0;
            sel_x      <= '0;
            sel_y      <= '0;
            move_req   <= 1'b0;
            move_src_x <= '0;
            move_src_y <= '0;
            move_dst_x <= '0;
            move_dst_y <= '0;
            move_fail  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel_valid  <= sel_valid_nxt;
            sel_x      <= sel_x_nxt;
            sel_y      <= sel_y_nxt;
            move_req   <= move_req_nxt;
            move_src_x <= move_src_x_nxt;
            move_src_y <= move_src_y_nxt;
            move_dst_x <= move_dst_x_nxt;
            move_dst_y <= move_dst_y_nxt;
            move_fail  <= move_fail_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_valid_nxt  = sel_valid;
        sel_x_nxt      = sel_x;
        sel_y_nxt      = sel_y;
        move_req_nxt   = move_req;
        move_src_x_nxt = move_src_x;
        move_src_y_nxt = move_src_y;
        move_dst_x_nxt = move_dst_x;
        move_dst_y_nxt = move_dst_y;
        move_fail_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (valid_click) begin
                    sel_x_nxt     = mouse_block_x;
                    sel_y_nxt     = mouse_block_y;
                    sel_valid_nxt = 1'b1;
                    state_nxt     = S_SRC;
                end
            end
            S_SRC: begin
                if (!en || r_click) begin
                    sel_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else if (valid_click && same_block) begin
                    sel_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else if (valid_click) begin
                    move_src_x_nxt = sel_x;
                    move_src_y_nxt = sel_y;
                    move_dst_x_nxt = mouse_block_x;
                    move_dst_y_nxt = mouse_block_y;
                    move_req_nxt   = 1'b1;
                    state_nxt      = S_REQ;
                end
            end
            S_REQ: begin
                // Ack outranks timeout and cancel: an accepted move never reports failure.
                if (move_ack) begin
                    move_req_nxt  = 1'b0;
                    sel_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else if (tmo_done || r_click) begin
                    move_req_nxt  = 1'b0;
                    sel_valid_nxt = 1'b0;
                    move_fail_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_REQ);

endmodule
